// File: rtl/pwm_3l_carrier_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_3l_carrier_if
// Description : Signal bundle between a modulation controller and the
//               three-level carrier PWM modulator.
//               master : drives en/period/ref_in/upd, observes outputs
//               slave  : the modulator itself
//   en       modulator enable
//   period   half carrier period in clocks (P)
//   ref_in   signed two's-complement modulation reference
//   upd      strobe: capture period and ref_in into the shadow registers
//   v_lev    commanded level 00=N, 01=O, 10=P
//   cnt_out  current carrier counter value
//   valley   one-cycle pulse on the first clock of the up phase
//   peak     one-cycle pulse on the first clock of the down phase
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_3l_carrier_if #(
    parameter int CNT_WIDTH = 16,
    parameter int REF_WIDTH = CNT_WIDTH + 1
);
    logic                        en;
    logic [CNT_WIDTH-1:0]        period;
    logic signed [REF_WIDTH-1:0] ref_in;
    logic                        upd;
    logic [1:0]                  v_lev;
    logic [CNT_WIDTH-1:0]        cnt_out;
    logic                        valley;
    logic                        peak;

    modport master (
        output en, period, ref_in, upd,
        input  v_lev, cnt_out, valley, peak
    );

    modport slave (
        input  en, period, ref_in, upd,
        output v_lev, cnt_out, valley, peak
    );
endinterface
`default_nettype wire

// File: rtl/pwm_3l_carrier.sv
`default_nettype none
// ============================================================================
// Module      : pwm_3l_carrier
// Description : Three-level carrier-based PWM modulator. A signed,
//               shadow-registered reference is compared against a symmetric
//               triangular counter (0..P-1 up, P-1..0 down, 2P clocks per
//               carrier). The commanded phase level N/O/P is produced every
//               clock with one clock of latency, together with valley/peak
//               sync strobes for ADC triggering. Feeds the v_lev input of the
//               3L NPC/NPP/ANPC decoder.
// Ports       : clk  - system clock
//               rst  - asynchronous, active-low reset
//               bus  - pwm_3l_carrier_if.slave (en, period, ref_in, upd in;
//                      v_lev, cnt_out, valley, peak out)
// Options     : PWM_DOUBLE_UPDATE_EN - when defined, shadow->active transfer
//               also happens on the edge entering a peak cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_3l_carrier #(
    parameter int CNT_WIDTH = 16,
    parameter int REF_WIDTH = CNT_WIDTH + 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    pwm_3l_carrier_if.slave bus
);

    // Magnitude comparisons are done in a width wide enough for both the
    // reference magnitude and the counter/period.
    localparam int c_CMP_W = (REF_WIDTH > CNT_WIDTH) ? REF_WIDTH : CNT_WIDTH;

    localparam logic [1:0]           c_LEV_N   = 2'b00;
    localparam logic [1:0]           c_LEV_O   = 2'b01;
    localparam logic [1:0]           c_LEV_P   = 2'b10;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

    // ST_IDLE doubles as "direction up, counter parked at 0".
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [CNT_WIDTH-1:0]        w_cnt_nxt;
    logic                        r_valley;
    logic                        w_valley_nxt;
    logic                        r_peak;
    logic                        w_peak_nxt;
    logic [1:0]                  r_v_lev;
    logic [1:0]                  w_v_lev_nxt;

    logic [CNT_WIDTH-1:0]        r_period_sh;
    logic signed [REF_WIDTH-1:0] r_ref_sh;
    logic [CNT_WIDTH-1:0]        r_period_act;
    logic signed [REF_WIDTH-1:0] r_ref_act;
    logic                        r_pend;
    logic                        w_pend_nxt;

    logic [CNT_WIDTH-1:0]        w_p_m1;
    logic                        w_valley_ent;
    logic                        w_peak_ent;
    logic                        w_xfer_win;
    logic                        w_xfer;
    logic [CNT_WIDTH-1:0]        w_period_src;
    logic signed [REF_WIDTH-1:0] w_ref_src;
    logic [CNT_WIDTH-1:0]        w_period_nxt;
    logic signed [REF_WIDTH-1:0] w_ref_nxt;

    logic [REF_WIDTH-1:0]        w_abs;
    logic [c_CMP_W-1:0]          w_abs_ext;
    logic [c_CMP_W-1:0]          w_p_ext;
    logic [c_CMP_W-1:0]          w_mag;
    logic [c_CMP_W-1:0]          w_cnt_ext;

    // ------------------------------------------------------------------
    // Carrier endpoints and shadow -> active transfer decision
    // ------------------------------------------------------------------
    always_comb begin
        w_p_m1       = r_period_act - c_CNT_ONE;
        w_valley_ent = (r_state == ST_DOWN) && (r_cnt == '0);
        w_peak_ent   = (r_state == ST_UP) && (r_cnt == w_p_m1);

        // While the modulator is not running (disabled, zero period, or
        // parked in idle) any pending update is taken immediately so that
        // the next carrier starts with fresh values.
`ifdef PWM_DOUBLE_UPDATE_EN
        w_xfer_win = !bus.en || (r_period_act == '0) || (r_state == ST_IDLE) ||
                     w_valley_ent || w_peak_ent;
`else
        w_xfer_win = !bus.en || (r_period_act == '0) || (r_state == ST_IDLE) ||
                     w_valley_ent;
`endif

        // An upd coinciding with the transfer edge bypasses the shadow
        // registers so the newest value is the one that takes effect.
        w_xfer       = w_xfer_win && (r_pend || bus.upd);
        w_period_src = bus.upd ? bus.period : r_period_sh;
        w_ref_src    = bus.upd ? bus.ref_in : r_ref_sh;
        w_period_nxt = w_xfer ? w_period_src : r_period_act;
        w_ref_nxt    = w_xfer ? w_ref_src    : r_ref_act;

        if (w_xfer) begin
            w_pend_nxt = 1'b0;
        end else if (bus.upd) begin
            w_pend_nxt = 1'b1;
        end else begin
            w_pend_nxt = r_pend;
        end
    end

    // ------------------------------------------------------------------
    // Carrier state / counter / strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_valley_nxt = 1'b0;
        w_peak_nxt   = 1'b0;

        if (!bus.en || (w_period_nxt == '0)) begin
            // Disable aborts the carrier at once; a zero period parks it.
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_UP: begin
                    if (w_peak_ent) begin
                        w_state_nxt = ST_DOWN;
                        w_peak_nxt  = 1'b1;
`ifdef PWM_DOUBLE_UPDATE_EN
                        // A period refreshed at the peak restarts the down
                        // phase from its own top value.
                        w_cnt_nxt   = w_period_nxt - c_CNT_ONE;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                ST_DOWN: begin
                    if (w_valley_ent) begin
                        w_state_nxt  = ST_UP;
                        w_cnt_nxt    = '0;
                        w_valley_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    // Leaving idle: the first running cycle is a valley.
                    w_state_nxt  = ST_UP;
                    w_cnt_nxt    = '0;
                    w_valley_nxt = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Reference magnitude, saturated to the active period
    // ------------------------------------------------------------------
    always_comb begin
        // The two's-complement negation of the most-negative value reads
        // back as 2^(REF_WIDTH-1) when treated as unsigned, which always
        // exceeds P and therefore saturates like any oversized reference.
        w_abs     = r_ref_act[REF_WIDTH-1] ? $unsigned(-r_ref_act)
                                           : $unsigned(r_ref_act);
        w_abs_ext = c_CMP_W'(w_abs);
        w_p_ext   = c_CMP_W'(r_period_act);
        w_mag     = (w_abs_ext > w_p_ext) ? w_p_ext : w_abs_ext;
        w_cnt_ext = c_CMP_W'(r_cnt);
    end

    // ------------------------------------------------------------------
    // Level decision (registered, one clock behind the counter)
    // ------------------------------------------------------------------
    always_comb begin
        w_v_lev_nxt = c_LEV_O;
        // mag > cnt >= 0 implies a non-zero reference, so the sign bit alone
        // selects between N and P.
        if (bus.en && (r_state != ST_IDLE) && (w_mag > w_cnt_ext)) begin
            w_v_lev_nxt = r_ref_act[REF_WIDTH-1] ? c_LEV_N : c_LEV_P;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_valley     <= 1'b0;
            r_peak       <= 1'b0;
            r_v_lev      <= c_LEV_O;
            r_period_sh  <= '0;
            r_ref_sh     <= '0;
            r_period_act <= '0;
            r_ref_act    <= '0;
            r_pend       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_valley     <= w_valley_nxt;
            r_peak       <= w_peak_nxt;
            r_v_lev      <= w_v_lev_nxt;
            r_period_act <= w_period_nxt;
            r_ref_act    <= w_ref_nxt;
            r_pend       <= w_pend_nxt;
            if (bus.upd) begin
                r_period_sh <= bus.period;
                r_ref_sh    <= bus.ref_in;
            end
        end
    end

    assign bus.v_lev   = r_v_lev;
    assign bus.cnt_out = r_cnt;
    assign bus.valley  = r_valley;
    assign bus.peak    = r_peak;

endmodule
`default_nettype wire

// File: doc/pwm_3l_carrier.md
Name: pwm_3l_carrier

Overview:
- Three-level carrier-based PWM modulator.
- Sits directly upstream of the 3L NPC/NPP/ANPC decoder and drives its 2-bit `v_lev` input.
- Compares a signed, shadow-registered reference against a symmetric triangular counter.
- Emits the commanded phase level (N/O/P) every clock, plus carrier valley/peak sync strobes for ADC triggering.

Parameters:
- CNT_WIDTH, 16, width of carrier counter and period.
- REF_WIDTH, CNT_WIDTH+1, width of the signed reference (two's complement).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  modulator enable
- period  in  CNT_WIDTH  half carrier period in clocks (P)
- ref_in  in  REF_WIDTH  signed modulation reference
- upd  in  1  strobe: capture period and ref_in into the shadow registers
- v_lev  out  2  commanded level: 2'b00 = N, 2'b01 = O, 2'b10 = P; 2'b11 is never driven
- cnt_out  out  CNT_WIDTH  current carrier counter value
- valley  out  1  one-cycle pulse on the first clock of the up phase
- peak  out  1  one-cycle pulse on the first clock of the down phase

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - v_lev = 2'b01
  - cnt_out = 0, direction = up
  - valley = 0, peak = 0
  - shadow and active period/ref = 0; pending flag = 0
- Shadow registers:
  - upd = 1 at a rising edge loads period_sh/ref_sh and sets pending.
  - A later upd overwrites the shadow registers; last write wins.
- Transfer (shadow -> active, pending cleared) happens on the edge that enters a valley cycle.
  - While period_act = 0 or en = 0, transfer happens on every edge where pending = 1, so the modulator can start.
- Carrier, for P = period_act ≥ 1:
  - Up phase: cnt = 0, 1, …, P-1.
  - Down phase: cnt = P-1, …, 0.
  - Each endpoint therefore dwells two clocks. Carrier period is 2P clocks.
  - P = 1 gives the sequence 0, 0, 0, … with valley and peak pulsing on alternate clocks.
- Strobes:
  - valley = 1 in the cycle where cnt = 0 and direction just became up.
  - peak = 1 in the cycle where cnt = P-1 and direction just became down.
- Magnitude and saturation:
  - mag = |ref_act|, computed in REF_WIDTH bits.
  - If mag > P, mag is saturated to P. The most-negative ref also saturates to P.
- Level decision, registered with 1-clock latency: v_lev(n+1) = f(cnt(n), ref_act(n)).
  - ref_act > 0 and mag > cnt -> P
  - ref_act < 0 and mag > cnt -> N
  - otherwise -> O
  - Result: the active level is held for exactly 2·mag of every 2P clocks, centred on the valley.
- Idle: en = 0 or period_act = 0.
  - Counter held at 0, direction up.
  - v_lev = O from the next clock; no valley or peak pulses.
- Enable transitions:
  - en deasserted mid-carrier: the counter aborts immediately (next edge cnt = 0).
  - en reasserted: the first enabled cycle is a valley cycle (valley = 1), with transfer if pending.
- A period change never truncates the current carrier; it takes effect only at a valley.
- Simultaneous upd and valley entry on the same edge: the new upd value is captured into shadow and transferred on the same edge (bypass).

Optional Feature:
- Macro: PWM_DOUBLE_UPDATE_EN.
- Defined: shadow -> active transfer also occurs on the edge entering a peak cycle (double-update PWM). A period change at a peak recomputes the down phase from the new P-1, clamped so cnt ≤ P-1.
- Undefined: transfer only at valleys, as above.

Test Plan:
- period = 100, ref_in = +50, upd, en = 1 -> v_lev = 2'b10 for 100 of every 200 clocks and 2'b01 otherwise; valley every 200 clocks; peak 100 clocks after each valley.
- ref_in = -30, period = 100 -> v_lev = 2'b00 for 60 clocks centred on each valley, 2'b01 otherwise; 2'b10 never seen.
- ref_in = +150, period = 100 -> v_lev constant 2'b10.
- ref_in = most-negative value -> v_lev constant 2'b00.
- upd with ref_in = +20 at cnt = 37 up-phase (active +50) -> current carrier keeps 100-clock P pulse; from next valley, P for 40 clocks. With PWM_DOUBLE_UPDATE_EN defined, the change applies from the next peak.
- en dropped at cnt = 60 -> next clock cnt = 0 and v_lev = 2'b01 on the following clock; en reasserted -> valley = 1 on the first cycle.
- rst asserted low mid down-phase -> outputs go to reset values immediately, without waiting for clk; after release with en = 1 and no upd, the block stays idle at v_lev = 2'b01 because period_act = 0.
